hvac_zone_ctrl: RTL and testbench

- Multi-zone hysteresis thermostat controller. Per zone it compares a measured temperature against a setpoint with a programmable dead band and drives heat, cool and idle outputs.
- Adds a global operating mode, minimum-on and minimum-off dwell timers for compressor protection, and demand counters.
- Sits between the sensor front-end (signed fixed-point temperature, 1/16 °C per LSB) and the actuator drivers.

---
 rtl/hvac_pkg.sv | 6 +
 rtl/hvac_zone_fsm.sv | 60 ++++++
 rtl/hvac_zone_ctrl.sv | 59 +++++
 tb/tb_hvac_zone_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/hvac_pkg.sv
// hvac_pkg: shared zone state, operating mode and temperature scaling for the HVAC zone controller.
package hvac_pkg;
  typedef enum logic [1:0] {IDLE, HEAT, COOL, LOCKOUT} zone_state_t;
  typedef enum logic [1:0] {MODE_OFF, MODE_HEAT, MODE_COOL, MODE_AUTO} mode_t;
  localparam int TEMP_LSB_PER_DEG_C = 16;
endpackage

// File: rtl/hvac_zone_fsm.sv
// hvac_zone_fsm: single-zone hysteresis thermostat with min-on/min-off dwell protection.
module hvac_zone_fsm
  import hvac_pkg::*;
#(
  parameter int T_W         = 12,
  parameter int MIN_ON_CYC  = 16,
  parameter int MIN_OFF_CYC = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_en_i,
  input  mode_t                 mode_i,
  input  logic signed [T_W-1:0] temp_i,
  input  logic signed [T_W-1:0] setpoint_i,
  input  logic        [T_W-1:0] band_i,
  output logic                  heat_o,
  output logic                  cool_o,
  output logic                  idle_o,
  output logic                  lockout_o,
  output logic                  heat_nxt_o,
  output logic                  cool_nxt_o
);
  localparam int DMAX = MIN_ON_CYC > MIN_OFF_CYC ? MIN_ON_CYC : MIN_OFF_CYC;
  localparam int DW   = $clog2(DMAX + 1);
  zone_state_t state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic signed [T_W+1:0] t_x, sp_x, b_x;
  logic heat_dem, cool_dem, heat_ok, cool_ok, min_on, min_off;
  // two guard bits make temp+band and setpoint+band overflow-free
  assign t_x      = {{2{temp_i[T_W-1]}}, temp_i};
  assign sp_x     = {{2{setpoint_i[T_W-1]}}, setpoint_i};
  assign b_x      = {2'b00, band_i};
  assign heat_dem = sp_x >= t_x + b_x;
  assign cool_dem = t_x >= sp_x + b_x;
  assign heat_ok  = mode_i == MODE_HEAT || mode_i == MODE_AUTO;
  assign cool_ok  = mode_i == MODE_COOL || mode_i == MODE_AUTO;
  assign min_on   = dwell_q >= DW'(MIN_ON_CYC - 1);
  assign min_off  = dwell_q >= DW'(MIN_OFF_CYC - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !sample_en_i ? IDLE : heat_dem && heat_ok ? HEAT : cool_dem && cool_ok ? COOL : IDLE;
      HEAT:    state_d = !heat_ok || (sample_en_i && temp_i >= setpoint_i && min_on) ? LOCKOUT : HEAT;
      COOL:    state_d = !cool_ok || (sample_en_i && temp_i <= setpoint_i && min_on) ? LOCKOUT : COOL;
      default: state_d = min_off ? IDLE : LOCKOUT;
    endcase
    if (reset) state_d = IDLE;
    dwell_d = state_d != state_q ? '0 : &dwell_q ? dwell_q : dwell_q + 1'b1;
  end
  assign heat_nxt_o = state_d == HEAT;
  assign cool_nxt_o = state_d == COOL;
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    dwell_q   <= reset ? '0 : dwell_d;
    heat_o    <= state_d == HEAT;
    cool_o    <= state_d == COOL;
    idle_o    <= state_d == IDLE;
    lockout_o <= state_d == LOCKOUT;
  end
endmodule

// File: rtl/hvac_zone_ctrl.sv
// hvac_zone_ctrl: multi-zone thermostat controller with global mode and registered demand counts.
module hvac_zone_ctrl
  import hvac_pkg::*;
#(
  parameter int N_ZONES     = 4,
  parameter int T_W         = 12,
  parameter int MIN_ON_CYC  = 16,
  parameter int MIN_OFF_CYC = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sample_en,
  input  logic [1:0]                     mode,
  input  logic [N_ZONES*T_W-1:0]         temp,
  input  logic [N_ZONES*T_W-1:0]         setpoint,
  input  logic [T_W-1:0]                 band,
  output logic [N_ZONES-1:0]             heat,
  output logic [N_ZONES-1:0]             cool,
  output logic [N_ZONES-1:0]             idle,
  output logic [N_ZONES-1:0]             lockout,
  output logic [$clog2(N_ZONES+1)-1:0]   heat_cnt,
  output logic [$clog2(N_ZONES+1)-1:0]   cool_cnt
);
  localparam int CW = $clog2(N_ZONES + 1);
  logic [N_ZONES-1:0] heat_nxt, cool_nxt;
  logic [CW-1:0] heat_cnt_d, cool_cnt_d;
  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    hvac_zone_fsm #(
      .T_W(T_W), .MIN_ON_CYC(MIN_ON_CYC), .MIN_OFF_CYC(MIN_OFF_CYC)
    ) u_fsm (
      .clk        (clk),
      .reset      (reset),
      .sample_en_i(sample_en),
      .mode_i     (mode_t'(mode)),
      .temp_i     ($signed(temp[z*T_W +: T_W])),
      .setpoint_i ($signed(setpoint[z*T_W +: T_W])),
      .band_i     (band),
      .heat_o     (heat[z]),
      .cool_o     (cool[z]),
      .idle_o     (idle[z]),
      .lockout_o  (lockout[z]),
      .heat_nxt_o (heat_nxt[z]),
      .cool_nxt_o (cool_nxt[z])
    );
  end
  // counts are taken from next-state so they land on the same edge as heat/cool
  always_comb begin
    heat_cnt_d = '0;
    cool_cnt_d = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      heat_cnt_d = heat_cnt_d + {{(CW-1){1'b0}}, heat_nxt[i]};
      cool_cnt_d = cool_cnt_d + {{(CW-1){1'b0}}, cool_nxt[i]};
    end
  end
  always_ff @(posedge clk) begin
    heat_cnt <= heat_cnt_d;
    cool_cnt <= cool_cnt_d;
  end
endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// tb_hvac_zone_ctrl: directed plus randomized checks of hvac_zone_ctrl against a run-length reference model.
module tb_hvac_zone_ctrl;
  localparam int NZ = 4, TW = 12, MIN_ON = 16, MIN_OFF = 8;
  logic clk = 0, rst = 1, se = 0;
  logic [1:0] md = 2'd3;
  logic [NZ*TW-1:0] temp_b, sp_b;
  logic [TW-1:0] band_b;
  logic [NZ-1:0] heat, cool, idle, lockout;
  logic [2:0] heat_cnt, cool_cnt;
  int t[NZ], sp[NZ], bnd;
  int checks = 0, errors = 0;
  bit m_heat[NZ], m_cool[NZ];
  int on_cyc[NZ], off_left[NZ];

  always #5 clk = ~clk;

  always_comb begin
    temp_b = '0;
    sp_b   = '0;
    for (int i = 0; i < NZ; i++) begin
      temp_b[i*TW +: TW] = TW'(t[i]);
      sp_b[i*TW +: TW]   = TW'(sp[i]);
    end
  end
  assign band_b = TW'(bnd);

  hvac_zone_ctrl #(.N_ZONES(NZ), .T_W(TW), .MIN_ON_CYC(MIN_ON), .MIN_OFF_CYC(MIN_OFF)) dut (
    .clk(clk), .reset(rst), .sample_en(se), .mode(md), .temp(temp_b), .setpoint(sp_b),
    .band(band_b), .heat(heat), .cool(cool), .idle(idle), .lockout(lockout),
    .heat_cnt(heat_cnt), .cool_cnt(cool_cnt)
  );

  // reference: zone tracks how long it has been running and how much lockout remains
  task automatic model_edge();
    for (int z = 0; z < NZ; z++) begin
      if (rst) begin
        m_heat[z] = 0; m_cool[z] = 0; off_left[z] = 0; on_cyc[z] = 0;
      end else if (m_heat[z]) begin
        if (md == 0 || md == 2 || (se && t[z] >= sp[z] && on_cyc[z] >= MIN_ON)) begin
          m_heat[z] = 0; off_left[z] = MIN_OFF;
        end else on_cyc[z]++;
      end else if (m_cool[z]) begin
        if (md == 0 || md == 1 || (se && t[z] <= sp[z] && on_cyc[z] >= MIN_ON)) begin
          m_cool[z] = 0; off_left[z] = MIN_OFF;
        end else on_cyc[z]++;
      end else if (off_left[z] > 0) begin
        off_left[z]--;
      end else if (se && sp[z] >= t[z] + bnd && (md == 1 || md == 3)) begin
        m_heat[z] = 1; on_cyc[z] = 1;
      end else if (se && t[z] >= sp[z] + bnd && (md == 2 || md == 3)) begin
        m_cool[z] = 1; on_cyc[z] = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [3:0] eh, ec, ei, el;
    for (int z = 0; z < NZ; z++) begin
      eh[z] = m_heat[z];
      ec[z] = m_cool[z];
      el[z] = off_left[z] > 0;
      ei[z] = !(m_heat[z] || m_cool[z] || off_left[z] > 0);
    end
    chk("heat", heat, eh);
    chk("cool", cool, ec);
    chk("idle", idle, ei);
    chk("lockout", lockout, el);
    chk("heat_cnt", {1'b0, heat_cnt}, 4'($countones(eh)));
    chk("cool_cnt", {1'b0, cool_cnt}, 4'($countones(ec)));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_model();
    end
  endtask

  initial begin
    for (int i = 0; i < NZ; i++) begin t[i] = 320; sp[i] = 320; end
    bnd = 32;
    tick(2);
    chk("reset_idle", idle, 4'hf);
    chk("reset_cnt", {1'b0, heat_cnt}, 4'd0);
    rst = 0;
    // heat cycle on zone 0
    t[0] = 280; se = 1;
    tick(1);
    chk("heat_start", {3'b0, heat[0]}, 4'd1);
    chk("heat_cnt_one", {1'b0, heat_cnt}, 4'd1);
    se = 0;
    tick(3);
    t[0] = 330; se = 1;
    tick(1);
    chk("min_on_hold", {3'b0, heat[0]}, 4'd1);
    tick(25);
    chk("heat_done_idle", {3'b0, idle[0]}, 4'd1);
    // hysteresis hold
    t[0] = 300; tick(1); chk("hyst_300", {3'b0, idle[0]}, 4'd1);
    t[0] = 340; tick(1); chk("hyst_340", {3'b0, idle[0]}, 4'd1);
    t[0] = 352; tick(1); chk("hyst_352", {3'b0, cool[0]}, 4'd1);
    t[0] = 330; tick(20); chk("cool_hold", {3'b0, cool[0]}, 4'd1);
    t[0] = 320; tick(1); chk("cool_exit", {3'b0, lockout[0]}, 4'd1);
    tick(10);
    // mode override on zone 1
    t[1] = 280; tick(1);
    se = 0; tick(2);
    md = 0; tick(1);
    chk("override_lock", {3'b0, lockout[1]}, 4'd1);
    chk("override_heat", heat, 4'd0);
    tick(10);
    md = 1; se = 1;
    for (int i = 0; i < NZ; i++) t[i] = 400;
    tick(20);
    chk("heat_only_no_cool", cool, 4'd0);
    // no direct reversal
    for (int i = 0; i < NZ; i++) t[i] = 320;
    md = 3; tick(1);
    t[0] = 280; tick(17);
    t[0] = 400; tick(1);
    chk("rev_lock", {3'b0, lockout[0]}, 4'd1);
    tick(7); chk("rev_lock_end", {3'b0, lockout[0]}, 4'd1);
    tick(1); chk("rev_idle", {3'b0, idle[0]}, 4'd1);
    tick(1); chk("rev_cool", {3'b0, cool[0]}, 4'd1);
    // reset while cooling
    rst = 1; tick(1);
    chk("rst_idle", idle, 4'hf);
    chk("rst_nolock", lockout, 4'h0);
    rst = 0;
    // multi-zone
    t[0] = 280; t[1] = 320; t[2] = 280; t[3] = 360;
    tick(1);
    chk("multi_heat", heat, 4'b0101);
    chk("multi_cool", cool, 4'b1000);
    chk("multi_hcnt", {1'b0, heat_cnt}, 4'd2);
    chk("multi_ccnt", {1'b0, cool_cnt}, 4'd1);
    // extremes
    rst = 1; tick(1); rst = 0;
    t[0] = -2048; sp[0] = 2047; bnd = 4095;
    tick(1);
    chk("extreme_heat", heat, 4'b0001);
    rst = 1; tick(1); rst = 0;
    sp[0] = 320; bnd = 32;
    // randomized phase
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
      se = $urandom_range(0, 2) != 0;
      for (int i = 0; i < NZ; i++) begin
        if ($urandom_range(0, 5) == 0) t[i] = 240 + $urandom_range(0, 160);
        if ($urandom_range(0, 60) == 0) sp[i] = 290 + $urandom_range(0, 60);
      end
      if ($urandom_range(0, 80) == 0) bnd = $urandom_range(0, 48);
      rst = $urandom_range(0, 199) == 0;
      tick(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
